// File: rtl/microseq_next_state.sv
// rtl/microseq_next_state.sv - microprogram sequencer: control-state register and next-state select
//
// Purpose: holds the current control state of the multicycle MIPS control unit and
// chooses the next state once per cycle from the decoded microinstruction, the
// instruction encoder's dispatch target, and datapath/memory status.
//
// Optional feature: define SEQ_WAIT_TIMEOUT_EN to build the wait watchdog, which
// forces a return to RESET_STATE after TIMEOUT consecutive holding cycles.
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      synchronous, active-high reset
//   i_n_sel      next-state source select (0..7)
//   i_s_sel      condition source: 0 moc, 1 cond, 2 const 0, 3 const 1
//   i_inv        inverts the selected condition
//   i_cr         literal next-state field
//   i_enc_state  dispatch target from the instruction encoder
//   i_moc        memory operation complete
//   i_cond       datapath branch/condition flag
//   o_state      current state, fed to the microstore
//   o_illegal    sticky: a computed next state was >= NUM_STATES
//   o_timeout    sticky: watchdog fired (0 when the watchdog is not built)

module microseq_next_state #(
  parameter int STATE_W     = 7,
  parameter int NUM_STATES  = 56,
  parameter int RESET_STATE = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [2:0]         i_n_sel,
  input  logic [1:0]         i_s_sel,
  input  logic               i_inv,
  input  logic [STATE_W-1:0] i_cr,
  input  logic [STATE_W-1:0] i_enc_state,
  input  logic               i_moc,
  input  logic               i_cond,
  output logic [STATE_W-1:0] o_state,
  output logic               o_illegal,
  output logic               o_timeout
);

  // Candidates are carried one bit wider so the incrementer carry-out is range-checked.
  localparam logic [STATE_W:0]   LP_NUM   = (STATE_W+1)'(NUM_STATES);
  localparam logic [STATE_W-1:0] LP_RESET = STATE_W'(RESET_STATE);

  logic [STATE_W-1:0] r_state;
  logic               r_illegal;

  logic               w_src;
  logic               w_c;
  logic [STATE_W:0]   w_inc;
  logic [STATE_W:0]   w_cand;
  logic               w_hold;
  logic               w_range_bad;
  logic               w_wd_fire;
  logic [STATE_W-1:0] w_next;

  // Next-state selection
  always_comb begin
    w_src = 1'b0;
    case (i_s_sel)
      2'd0: w_src = i_moc;
      2'd1: w_src = i_cond;
      2'd2: w_src = 1'b0;
      2'd3: w_src = 1'b1;
      default: w_src = 1'b0;
    endcase
    w_c   = w_src ^ i_inv;
    w_inc = {1'b0, r_state} + 1'b1;

    w_cand = {1'b0, r_state};
    case (i_n_sel)
      3'd0: w_cand = {1'b0, i_enc_state};
      3'd1: w_cand = {1'b0, LP_RESET};
      3'd2: w_cand = {1'b0, i_cr};
      3'd3: w_cand = w_inc;
      3'd4: w_cand = w_c ? {1'b0, i_cr} : w_inc;
      3'd5: w_cand = w_c ? w_inc : {1'b0, r_state};
      3'd6: w_cand = w_c ? {1'b0, i_enc_state} : w_inc;
      3'd7: w_cand = w_c ? {1'b0, i_cr} : {1'b0, LP_RESET};
      default: w_cand = {1'b0, r_state};
    endcase

    // Only an unsatisfied wait counts as holding; it is what the watchdog watches.
    w_hold      = (i_n_sel == 3'd5) && !w_c;
    w_range_bad = (w_cand >= LP_NUM);
    w_next      = (w_range_bad || w_wd_fire) ? LP_RESET : w_cand[STATE_W-1:0];
  end

`ifdef SEQ_WAIT_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout;

  // r_wait_cnt counts holding cycles already completed, so the current holding
  // cycle is number r_wait_cnt+1; the watchdog fires on the TIMEOUT-th one.
  assign w_wd_fire = w_hold && (r_wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (!w_hold || w_wd_fire) begin
        r_wait_cnt <= '0;
      end else begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_wd_fire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_wd_fire = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // State register and sticky range flag
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= LP_RESET;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_range_bad) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    o_state   = r_state;
    o_illegal = r_illegal;
  end

endmodule

// File: tb/tb_microseq_next_state.sv
// tb/tb_microseq_next_state.sv - self-checking bench for microseq_next_state

module tb_microseq_next_state;

  logic       clk;
  logic       reset;
  logic [2:0] n_sel;
  logic [1:0] s_sel;
  logic       inv;
  logic [6:0] cr;
  logic [6:0] enc_state;
  logic       moc;
  logic       cond;
  logic [6:0] state;
  logic       illegal;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  microseq_next_state #(
    .STATE_W(7), .NUM_STATES(56), .RESET_STATE(0), .TIMEOUT(5)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_n_sel(n_sel), .i_s_sel(s_sel), .i_inv(inv),
    .i_cr(cr), .i_enc_state(enc_state), .i_moc(moc), .i_cond(cond),
    .o_state(state), .o_illegal(illegal), .o_timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] n;
    logic [1:0] s;
    logic       inv;
    logic [6:0] cr;
    logic [6:0] enc;
    logic       moc;
    logic       cond;
    logic [6:0] es;
    logic       eil;
  } vec_t;

  typedef struct {
    string      name;
    logic [6:0] st;
    logic       il;
    logic       to;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(string nm, logic r, logic [2:0] n, logic [1:0] s, logic iv,
                              logic [6:0] c, logic [6:0] e, logic m, logic cd,
                              logic [6:0] es, logic eil);
    vec_t v;
    v.name = nm; v.rst = r; v.n = n; v.s = s; v.inv = iv; v.cr = c; v.enc = e;
    v.moc = m; v.cond = cd; v.es = es; v.eil = eil;
    return v;
  endfunction

  task automatic step(string nm, logic r, logic [2:0] n, logic [1:0] s, logic iv,
                      logic [6:0] c, logic [6:0] e, logic m, logic cd,
                      logic [6:0] es, logic eil, logic eto);
    exp_t x;
    exp_t got;
    reset = r; n_sel = n; s_sel = s; inv = iv; cr = c; enc_state = e; moc = m; cond = cd;
    x.name = nm; x.st = es; x.il = eil; x.to = eto;
    sb.push_back(x);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checks++;
    if (state !== got.st) begin
      failures++;
      $display("FAIL %s state: got=%0d expected=%0d", got.name, state, got.st);
    end
    checks++;
    if (illegal !== got.il) begin
      failures++;
      $display("FAIL %s illegal: got=%0b expected=%0b", got.name, illegal, got.il);
    end
    checks++;
    if (timeout !== got.to) begin
      failures++;
      $display("FAIL %s timeout: got=%0b expected=%0b", got.name, timeout, got.to);
    end
  endtask

  initial begin
    reset = 1'b1; n_sel = '0; s_sel = '0; inv = 1'b0; cr = '0; enc_state = '0;
    moc = 1'b0; cond = 1'b0;

    //                name          rst n  s  inv cr  enc moc cond  state ill
    tbl.push_back(mk("reset0",      1, 0, 0, 0,  0,  0,  0, 0,    0,  0));
    tbl.push_back(mk("reset1",      1, 0, 0, 0,  0,  0,  0, 0,    0,  0));
    tbl.push_back(mk("dispatch6",   0, 0, 0, 0,  0,  6,  0, 0,    6,  0));
    tbl.push_back(mk("dispatch7",   0, 0, 0, 0,  0,  7,  0, 0,    7,  0));
    tbl.push_back(mk("inc7",        0, 3, 0, 0,  0,  0,  0, 0,    8,  0));
    tbl.push_back(mk("br_taken",    0, 4, 1, 0, 30,  0,  0, 1,   30,  0));
    tbl.push_back(mk("br_fall",     0, 4, 1, 0, 30,  0,  0, 0,   31,  0));
    tbl.push_back(mk("br_inv",      0, 4, 1, 1, 30,  0,  0, 0,   30,  0));
    tbl.push_back(mk("n7_const1",   0, 7, 3, 0, 20,  0,  0, 0,   20,  0));
    tbl.push_back(mk("n7_const0",   0, 7, 2, 0, 20,  0,  0, 0,    0,  0));
    tbl.push_back(mk("load10",      0, 2, 0, 0, 10,  0,  0, 0,   10,  0));
    tbl.push_back(mk("moc_wait1",   0, 5, 0, 0,  0,  0,  0, 0,   10,  0));
    tbl.push_back(mk("moc_wait2",   0, 5, 0, 0,  0,  0,  0, 0,   10,  0));
    tbl.push_back(mk("moc_wait3",   0, 5, 0, 0,  0,  0,  0, 0,   10,  0));
    tbl.push_back(mk("moc_wait4",   0, 5, 0, 0,  0,  0,  0, 0,   10,  0));
    tbl.push_back(mk("moc_done",    0, 5, 0, 0,  0,  0,  1, 0,   11,  0));
    tbl.push_back(mk("moc_inv_hold",0, 5, 0, 1,  0,  0,  1, 0,   11,  0));
    tbl.push_back(mk("n6_enc",      0, 6, 1, 0,  0, 40,  0, 1,   40,  0));
    tbl.push_back(mk("n6_inc",      0, 6, 1, 0,  0, 40,  0, 0,   41,  0));
    tbl.push_back(mk("n1_ret",      0, 1, 0, 0, 33, 33,  1, 1,    0,  0));
    tbl.push_back(mk("load55",      0, 2, 0, 0, 55,  0,  0, 0,   55,  0));
    tbl.push_back(mk("inc_ovr",     0, 3, 0, 0,  0,  0,  0, 0,    0,  1));
    tbl.push_back(mk("cr60",        0, 2, 0, 0, 60,  0,  0, 0,    0,  1));
    tbl.push_back(mk("sticky_ill",  0, 0, 0, 0,  0, 20,  0, 0,   20,  1));
    tbl.push_back(mk("reset_clr",   1, 0, 0, 0,  0,  0,  0, 0,    0,  0));
    tbl.push_back(mk("load55b",     0, 2, 0, 0, 55,  0,  0, 0,   55,  0));
    tbl.push_back(mk("n5_inc_ovr",  0, 5, 3, 0,  0,  0,  0, 0,    0,  1));
    tbl.push_back(mk("reset_ovr",   1, 2, 3, 0, 30,  0,  0, 0,    0,  0));
    tbl.push_back(mk("n6_c0_inc",   0, 6, 2, 0,  0, 40,  0, 0,    1,  0));
    tbl.push_back(mk("enc56",       0, 0, 0, 0,  0, 56,  0, 0,    0,  1));
    tbl.push_back(mk("reset_again", 1, 0, 0, 0,  0,  0,  0, 0,    0,  0));
    tbl.push_back(mk("load54",      0, 2, 0, 0, 54,  0,  0, 0,   54,  0));
    tbl.push_back(mk("inc_to_55",   0, 3, 0, 0,  0,  0,  0, 0,   55,  0));

    foreach (tbl[i]) begin
      step(tbl[i].name, tbl[i].rst, tbl[i].n, tbl[i].s, tbl[i].inv, tbl[i].cr,
           tbl[i].enc, tbl[i].moc, tbl[i].cond, tbl[i].es, tbl[i].eil, 1'b0);
    end

    // Long wait in state 10: watchdog fires on the 5th holding cycle when built.
    step("rst_wd", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("load10_wd", 0, 2, 0, 0, 10, 0, 0, 0, 10, 0, 0);
`ifdef SEQ_WAIT_TIMEOUT_EN
    for (int i = 0; i < 5; i++) begin
      step($sformatf("wd_hold%0d", i), 0, 5, 0, 0, 0, 0, 0, 0,
           (i < 4) ? 7'd10 : 7'd0, 0, (i < 4) ? 1'b0 : 1'b1);
    end
`else
    for (int i = 0; i < 25; i++) begin
      step($sformatf("long_hold%0d", i), 0, 5, 0, 0, 0, 0, 0, 0, 10, 0, 0);
    end
`endif

    // Reset in the middle of a wait in state 53, then keep holding in state 0.
    step("rst_mw", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("load53", 0, 2, 0, 0, 53, 0, 0, 0, 53, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("hold53_%0d", i), 0, 5, 0, 0, 0, 0, 0, 0, 53, 0, 0);
    end
    step("rst_in_wait", 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
`ifdef SEQ_WAIT_TIMEOUT_EN
      step($sformatf("post_rst_hold%0d", i), 0, 5, 0, 0, 0, 0, 0, 0, 0, 0,
           (i < 4) ? 1'b0 : 1'b1);
`else
      step($sformatf("post_rst_hold%0d", i), 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
